// File: rtl/cla_adder_reg.sv
// Registered N-bit two-level carry-look-ahead adder: {C_out,S} = A + B + C_in, one-cycle latency.
// Optional signed-overflow output V is compiled in when CLA_OVERFLOW_EN is defined.
module cla_adder_reg #(
    parameter int unsigned N     = 4,
    parameter int unsigned GROUP = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         C_in,
    output logic [N-1:0] S,
    output logic         C_out,
    output logic         out_valid
`ifdef CLA_OVERFLOW_EN
    ,
    output logic         V
`endif
);

    localparam int unsigned NG  = (N + GROUP - 1) / GROUP;
    localparam int          NI  = int'(N);
    localparam int          GI  = int'(GROUP);
    localparam int          NGI = int'(NG);

    logic [N-1:0]  w_g;
    logic [N-1:0]  w_p;
    logic [NG-1:0] w_gg;
    logic [NG-1:0] w_gp;
    logic [NG-1:0] w_gc;
    logic [N:0]    w_c;

    logic [N-1:0]  r_s;
    logic          r_c_out;
    logic          r_valid;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Group generate/propagate; the MSB group may be partial, so bits past N are skipped.
    always_comb begin : group_terms
        logic v_t;
        v_t  = 1'b0;
        w_gg = '0;
        w_gp = '1;
        for (int k = 0; k < NGI; k++) begin
            for (int i = 0; i < GI; i++) begin
                if (k * GI + i < NI) begin
                    w_gp[k] = w_gp[k] & w_p[k * GI + i];
                    v_t = w_g[k * GI + i];
                    for (int m = i + 1; m < GI; m++) begin
                        if (k * GI + m < NI) begin
                            v_t = v_t & w_p[k * GI + m];
                        end
                    end
                    w_gg[k] = w_gg[k] | v_t;
                end
            end
        end
    end

    // Second lookahead level: every group carry-in is a flat product sum of GG/GP and C_in.
    always_comb begin : group_carry
        logic v_t;
        v_t  = 1'b0;
        w_gc = '0;
        for (int k = 0; k < NGI; k++) begin
            v_t = C_in;
            for (int m = 0; m < k; m++) begin
                v_t = v_t & w_gp[m];
            end
            w_gc[k] = v_t;
            for (int j = 0; j < k; j++) begin
                v_t = w_gg[j];
                for (int m = j + 1; m < k; m++) begin
                    v_t = v_t & w_gp[m];
                end
                w_gc[k] = w_gc[k] | v_t;
            end
        end
    end

    // In-group carries expanded from the group carry-in, no ripple between bits.
    always_comb begin : bit_carry
        logic v_t;
        v_t    = 1'b0;
        w_c    = '0;
        w_c[0] = C_in;
        for (int k = 0; k < NGI; k++) begin
            for (int i = 0; i < GI; i++) begin
                if (k * GI + i < NI) begin
                    v_t = w_gc[k];
                    for (int m = 0; m <= i; m++) begin
                        v_t = v_t & w_p[k * GI + m];
                    end
                    w_c[k * GI + i + 1] = v_t;
                    for (int j = 0; j <= i; j++) begin
                        v_t = w_g[k * GI + j];
                        for (int m = j + 1; m <= i; m++) begin
                            v_t = v_t & w_p[k * GI + m];
                        end
                        w_c[k * GI + i + 1] = w_c[k * GI + i + 1] | v_t;
                    end
                end
            end
        end
    end

    // Output register: loads on in_valid, otherwise holds; valid is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s     <= '0;
            r_c_out <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_s     <= w_p ^ w_c[N-1:0];
                r_c_out <= w_c[N];
            end
        end
    end

    assign S         = r_s;
    assign C_out     = r_c_out;
    assign out_valid = r_valid;

`ifdef CLA_OVERFLOW_EN
    logic r_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= 1'b0;
        end else if (in_valid) begin
            r_v <= w_c[N] ^ w_c[N-1];
        end
    end

    assign V = r_v;
`endif

endmodule

// File: tb/tb_cla_adder_reg.sv
// Randomised and directed bench for cla_adder_reg against an arithmetic reference model.
// Three instances: N=4/GROUP=4, N=13/GROUP=4 (partial group), N=4/GROUP=1.
module tb_cla_adder_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_iv, a_ci, a_co, a_ov;
    logic [3:0]  a_a, a_b, a_s;
    logic        b_iv, b_ci, b_co, b_ov;
    logic [12:0] b_a, b_b, b_s;
    logic        c_iv, c_ci, c_co, c_ov;
    logic [3:0]  c_a, c_b, c_s;
`ifdef CLA_OVERFLOW_EN
    logic        a_v, b_v, c_v;
`endif

    cla_adder_reg #(.N(4), .GROUP(4)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .A(a_a), .B(a_b), .C_in(a_ci),
        .S(a_s), .C_out(a_co), .out_valid(a_ov)
`ifdef CLA_OVERFLOW_EN
        , .V(a_v)
`endif
    );

    cla_adder_reg #(.N(13), .GROUP(4)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .A(b_a), .B(b_b), .C_in(b_ci),
        .S(b_s), .C_out(b_co), .out_valid(b_ov)
`ifdef CLA_OVERFLOW_EN
        , .V(b_v)
`endif
    );

    cla_adder_reg #(.N(4), .GROUP(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .A(c_a), .B(c_b), .C_in(c_ci),
        .S(c_s), .C_out(c_co), .out_valid(c_ov)
`ifdef CLA_OVERFLOW_EN
        , .V(c_v)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_s  [3];
    logic        exp_co [3];
    logic        exp_v  [3];
    logic        exp_ov [3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide addition; overflow from the operand/result sign rule.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic ci);
        logic [63:0] mask;
        logic [64:0] sum;
        logic [63:0] s;
        logic        co;
        logic        v;
        mask = (64'd1 << w) - 64'd1;
        sum  = {1'b0, a & mask} + {1'b0, b & mask} + 65'(ci);
        s    = sum[63:0] & mask;
        co   = sum[w];
        v    = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return {v, co, s};
    endfunction

    task automatic check_all();
        check("a_out", 64'({a_ov, a_co, a_s}), 64'({exp_ov[0], exp_co[0], exp_s[0][3:0]}));
        check("b_out", 64'({b_ov, b_co, b_s}), 64'({exp_ov[1], exp_co[1], exp_s[1][12:0]}));
        check("c_out", 64'({c_ov, c_co, c_s}), 64'({exp_ov[2], exp_co[2], exp_s[2][3:0]}));
`ifdef CLA_OVERFLOW_EN
        check("a_v", 64'(a_v), 64'(exp_v[0]));
        check("b_v", 64'(b_v), 64'(exp_v[1]));
        check("c_v", 64'(c_v), 64'(exp_v[2]));
`endif
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            exp_s[i]  = '0;
            exp_co[i] = 1'b0;
            exp_v[i]  = 1'b0;
            exp_ov[i] = 1'b0;
        end
    endtask

    // Called just after a falling edge with inputs set; advances one cycle and checks.
    task automatic tick();
        logic [65:0] r;
        if (!rst_n) begin
            clear_model();
        end else begin
            r = ref_add(4, 64'(a_a), 64'(a_b), a_ci);
            exp_ov[0] = a_iv;
            if (a_iv) begin exp_s[0] = r[63:0]; exp_co[0] = r[64]; exp_v[0] = r[65]; end
            r = ref_add(13, 64'(b_a), 64'(b_b), b_ci);
            exp_ov[1] = b_iv;
            if (b_iv) begin exp_s[1] = r[63:0]; exp_co[1] = r[64]; exp_v[1] = r[65]; end
            r = ref_add(4, 64'(c_a), 64'(c_b), c_ci);
            exp_ov[2] = c_iv;
            if (c_iv) begin exp_s[2] = r[63:0]; exp_co[2] = r[64]; exp_v[2] = r[65]; end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic randomize_inputs(input bit force_valid);
        a_iv = force_valid ? 1'b1 : 1'(($urandom % 5) != 0);
        b_iv = force_valid ? 1'b1 : 1'(($urandom % 5) != 0);
        c_iv = force_valid ? 1'b1 : 1'(($urandom % 5) != 0);
        a_a = 4'($urandom);  a_b = 4'($urandom);  a_ci = 1'($urandom);
        b_a = 13'($urandom); b_b = 13'($urandom); b_ci = 1'($urandom);
        c_a = 4'($urandom);  c_b = 4'($urandom);  c_ci = 1'($urandom);
    endtask

    logic [3:0] d_a   [4];
    logic [3:0] d_b   [4];
    logic       d_ci  [4];
    logic [5:0] d_exp [4];
    logic       d_v   [4];

    initial begin
        d_a   = '{4'b1011, 4'b0101, 4'b1001, 4'b1111};
        d_b   = '{4'b1101, 4'b0011, 4'b0110, 4'b1111};
        d_ci  = '{1'b0, 1'b0, 1'b1, 1'b0};
        d_exp = '{6'b1_1_1000, 6'b1_0_1000, 6'b1_1_0000, 6'b1_1_1110};
        d_v   = '{1'b0, 1'b1, 1'b0, 1'b0};
        clear_model();

        // Reset held with valid, nonzero operands: outputs stay cleared across edges.
        rst_n = 1'b1;
        randomize_inputs(1'b1);
        a_a = 4'b1011; a_b = 4'b1101;
        #1 rst_n = 1'b0;
        #1 check_all();
        @(posedge clk); #1 check_all();
        @(posedge clk); #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors back to back on the N=4 instance, then hold.
        b_iv = 1'b0;
        c_iv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_iv = 1'b1; a_a = d_a[i]; a_b = d_b[i]; a_ci = d_ci[i];
            tick();
            check("dir_out", 64'({a_ov, a_co, a_s}), 64'(d_exp[i]));
`ifdef CLA_OVERFLOW_EN
            check("dir_v", 64'(a_v), 64'(d_v[i]));
`endif
        end
        for (int i = 0; i < 2; i++) begin
            a_iv = 1'b0; a_a = 4'($urandom); a_b = 4'($urandom); a_ci = 1'($urandom);
            tick();
            check("hold", 64'({a_ov, a_co, a_s}), 64'(6'b0_1_1110));
        end

        // Exhaustive N=4 on both GROUP settings, N=13 random alongside.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int z = 0; z < 2; z++) begin
                    randomize_inputs(1'b1);
                    a_a = 4'(x); a_b = 4'(y); a_ci = 1'(z);
                    c_a = 4'(x); c_b = 4'(y); c_ci = 1'(z);
                    tick();
                end
            end
        end

        // Random sweep with sporadic idle cycles.
        for (int n = 0; n < 10000; n++) begin
            randomize_inputs(1'b0);
            tick();
        end

        // Reset asserted between edges while results are held: immediate clear.
        randomize_inputs(1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 clear_model();
        check_all();
        @(posedge clk); #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            randomize_inputs(1'b0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
